// File: rtl/alu_pkg.sv
// Shared opcode and request types for the ALU and its two-requester front end.
// Imported by alu, alu_arbiter and the bench.
package alu_pkg;

  localparam int DW = 8;
  localparam int YW = 16;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    XOR = 2'd3
  } opcode_e;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    opcode_e       op;
    logic          id;
  } alu_req_t;

  function automatic logic [YW-1:0] sat_inc(input logic [YW-1:0] v);
    return (v == {YW{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU with a 16-bit result.
// Operands are zero-extended; SUB wraps modulo 2^16.
module alu
  import alu_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  opcode_e       op,
  output logic [YW-1:0] y
);

  logic [YW-1:0] ax;
  logic [YW-1:0] bx;

  assign ax = {{(YW-DW){1'b0}}, a};
  assign bx = {{(YW-DW){1'b0}}, b};

  always_comb begin
    y = '0;
    unique case (op)
      ADD:     y = ax + bx;
      SUB:     y = ax - bx;
      MUL:     y = ax * bx;
      XOR:     y = ax ^ bx;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one ALU between two requesters.
// One operation in flight: IDLE grants, EXEC computes, RESP holds the result.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter logic PTR_INIT = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  input  logic [DW-1:0] req_a0,
  input  logic [DW-1:0] req_a1,
  input  logic [DW-1:0] req_b0,
  input  logic [DW-1:0] req_b1,
  input  opcode_e       req_op0,
  input  opcode_e       req_op1,
  output logic [1:0]    req_ready,
  output logic          rsp_valid,
  output logic          rsp_id,
  output logic [YW-1:0] rsp_y,
  input  logic          rsp_ready,
  output logic [15:0]   ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e        state_q;
  logic          ptr_q;
  alu_req_t      cur_q;
  logic [1:0]    gnt;
  logic          gid;
  alu_req_t      sel;
  logic [YW-1:0] alu_y;
  logic [15:0]   ops_done_q;

  always_comb begin
    gnt = 2'b00;
    if (state_q == IDLE && !rst) begin
      unique case (req_valid)
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign gid       = gnt[1];
  assign req_ready = gnt;
  assign ops_done  = ops_done_q;

  always_comb begin
    sel.a  = gid ? req_a1  : req_a0;
    sel.b  = gid ? req_b1  : req_b0;
    sel.op = gid ? req_op1 : req_op0;
    sel.id = gid;
  end

  alu u_alu (
    .a  (cur_q.a),
    .b  (cur_q.b),
    .op (cur_q.op),
    .y  (alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_INIT;
      cur_q      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_y      <= '0;
      ops_done_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt != 2'b00) begin
            cur_q   <= sel;
            rsp_id  <= gid;
            ptr_q   <= ~gid;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_y     <= alu_y;
          rsp_valid <= 1'b1;
          state_q   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            ops_done_q <= sat_inc(ops_done_q);
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: grant, latency, backpressure,
// mid-op reset, round-robin contention and ops_done saturation.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [7:0]    req_a0, req_a1, req_b0, req_b1;
  opcode_e       req_op0, req_op1;
  logic [1:0]    req_ready;
  logic          rsp_valid;
  logic          rsp_id;
  logic [15:0]   rsp_y;
  logic          rsp_ready;
  logic [15:0]   ops_done;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.PTR_INIT(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a0    (req_a0),
    .req_a1    (req_a1),
    .req_b0    (req_b0),
    .req_b1    (req_b1),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_ready (rsp_ready),
    .ops_done  (ops_done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    logic [1:0]  exp_gnt [4];
    logic        exp_id  [4];
    logic [15:0] exp_y   [4];
    logic [15:0] exp_cnt [5];

    rst = 1'b1;
    req_valid = 2'b11;
    req_a0 = 8'd0; req_b0 = 8'd0; req_op0 = ADD;
    req_a1 = 8'd0; req_b1 = 8'd0; req_op1 = ADD;
    rsp_ready = 1'b1;
    step;
    step;
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_y", {16'd0, rsp_y}, 32'd0);
    chk("rst_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_cnt", {16'd0, ops_done}, 32'd0);

    // Single ADD from requester 0
    rst = 1'b0;
    req_valid = 2'b01;
    req_a0 = 8'd200; req_b0 = 8'd100; req_op0 = ADD;
    settle;
    chk("t1_gnt", {30'd0, req_ready}, 32'h1);
    step;
    req_valid = 2'b00;
    settle;
    chk("t1_exec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t1_exec_ready", {30'd0, req_ready}, 32'd0);
    step;
    chk("t1_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t1_y", {16'd0, rsp_y}, 32'd300);
    chk("t1_id", {31'd0, rsp_id}, 32'd0);
    chk("t1_cnt_pre", {16'd0, ops_done}, 32'd0);
    step;
    chk("t1_cnt", {16'd0, ops_done}, 32'd1);
    chk("t1_done", {31'd0, rsp_valid}, 32'd0);

    // Lone req0 against pointer=1, then 5 cycles of backpressure
    req_valid = 2'b01;
    req_a0 = 8'd3; req_b0 = 8'd5; req_op0 = SUB;
    rsp_ready = 1'b0;
    settle;
    chk("bp_gnt", {30'd0, req_ready}, 32'h1);
    step;
    req_valid = 2'b11;
    step;
    for (int i = 0; i < 5; i++) begin
      settle;
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_y", {16'd0, rsp_y}, 32'hFFFE);
      chk("bp_id", {31'd0, rsp_id}, 32'd0);
      chk("bp_ready", {30'd0, req_ready}, 32'd0);
      chk("bp_cnt", {16'd0, ops_done}, 32'd1);
      step;
    end
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    step;
    chk("bp_cnt_post", {16'd0, ops_done}, 32'd2);

    // Grant req0 (pointer -> 1), then reset while in EXEC
    req_valid = 2'b01;
    req_a0 = 8'd1; req_b0 = 8'd1; req_op0 = ADD;
    step;
    rst = 1'b1;
    req_valid = 2'b11;
    settle;
    chk("mr_ready_exec", {30'd0, req_ready}, 32'd0);
    step;
    chk("mr_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mr_cnt", {16'd0, ops_done}, 32'd0);
    chk("mr_ready_rst", {30'd0, req_ready}, 32'd0);
    rst = 1'b0;

    // Contention: pointer restored to 0, grants alternate 0,1,0,1
    req_a0 = 8'd255; req_b0 = 8'd255; req_op0 = MUL;
    req_a1 = 8'd3;   req_b1 = 8'd5;   req_op1 = SUB;
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_y   = '{16'hFE01, 16'hFFFE, 16'hFE01, 16'hFFFE};
    for (int i = 0; i < 4; i++) begin
      settle;
      chk("rr_gnt", {30'd0, req_ready}, {30'd0, exp_gnt[i]});
      step;
      chk("rr_hold", {30'd0, req_ready}, 32'd0);
      step;
      chk("rr_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rr_id", {31'd0, rsp_id}, {31'd0, exp_id[i]});
      chk("rr_y", {16'd0, rsp_y}, {16'd0, exp_y[i]});
      step;
    end
    chk("rr_cnt", {16'd0, ops_done}, 32'd4);

    // Lone req1 with pointer=0 after reset
    req_valid = 2'b00;
    rst = 1'b1;
    step;
    rst = 1'b0;
    req_valid = 2'b10;
    req_a1 = 8'hAA; req_b1 = 8'h55; req_op1 = XOR;
    settle;
    chk("lone_gnt", {30'd0, req_ready}, 32'h2);
    step;
    req_valid = 2'b11;
    step;
    chk("lone_id", {31'd0, rsp_id}, 32'd1);
    chk("lone_y", {16'd0, rsp_y}, 32'h00FF);
    step;
    settle;
    chk("lone_ptr", {30'd0, req_ready}, 32'h1);
    req_valid = 2'b00;
    step;

    // Saturation: preload the counter near the top, then handshake
    force dut.ops_done_q = 16'hFFFC;
    #1;
    release dut.ops_done_q;
    req_a0 = 8'hAA; req_b0 = 8'h55; req_op0 = XOR;
    exp_cnt = '{16'hFFFD, 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    for (int i = 0; i < 5; i++) begin
      req_valid = 2'b01;
      step;
      req_valid = 2'b00;
      step;
      chk("sat_y", {16'd0, rsp_y}, 32'h00FF);
      step;
      chk("sat_cnt", {16'd0, ops_done}, {16'd0, exp_cnt[i]});
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter PTR_INIT, default 1'b0, initial round-robin priority pointer (0 = requester 0 favoured).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req_valid[1:0]  input  2  per-requester operation request.
REQ-005 SHALL have ports req_a0, req_a1, req_b0, req_b1  input  8 each  operands for requesters 0/1.
REQ-006 SHALL have ports req_op0, req_op1  input  opcode_e (2)  operation for requesters 0/1.
REQ-007 SHALL have port req_ready  output  2  per-requester accept strobe.
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_id  output  1  index of requester owning the result.
REQ-010 SHALL have port rsp_y  output  16  ALU result.
REQ-011 SHALL have port rsp_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port ops_done  output  16  count of completed responses.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-014 In IDLE, SHALL grant a requester whose req_valid is high, with req_ready for that requester asserted combinationally in the same cycle; request transfers on req_valid && req_ready.
REQ-015 Only one bit of req_ready SHALL ever be high; req_ready SHALL be 2'b00 outside IDLE.
REQ-016 Both valid: SHALL grant the requester selected by the priority pointer; exactly one valid: SHALL grant it regardless of pointer.
REQ-017 On each grant, pointer SHALL become the index of the non-granted requester (round-robin).
REQ-018 On grant, SHALL register a, b, op and grantee id; IDLE -> EXEC.
REQ-019 In EXEC, SHALL drive the registered operands into the ALU and register its 16-bit output into rsp_y; EXEC -> RESP after exactly one cycle.
REQ-020 Arithmetic SHALL match ALU: ADD/SUB/MUL on 8-bit operands zero-extended to 16 bits; SUB wraps modulo 2^16 (3-5 = 16'hFFFE); XOR upper byte 0.
REQ-021 In RESP, rsp_valid SHALL be high and rsp_y/rsp_id stable until rsp_ready is high; on rsp_valid && rsp_ready -> IDLE.
REQ-022 Latency: grant in cycle N -> rsp_valid first high in cycle N+2; new grant no earlier than the cycle after the response handshake.
REQ-023 ops_done SHALL increment by 1 on each response handshake and saturate at 16'hFFFF.
REQ-024 Requests arriving in EXEC/RESP SHALL be held off (req_ready low), not dropped; requesters keep req_valid asserted.

Reset
REQ-025 rst high SHALL, at the next clk edge, force IDLE, pointer = PTR_INIT, ops_done = 0, rsp_valid = 0, rsp_y = 0, rsp_id = 0, req_ready = 0 during reset.
REQ-026 rst during EXEC or RESP SHALL abandon the in-flight operation with no response and no ops_done increment.

Structure
REQ-027 opcode_e {ADD, SUB, MUL, XOR} SHALL be declared in shared package alu_pkg, imported by alu, alu_arbiter and bench.
REQ-028 SHALL instantiate the existing alu module once as the sole datapath sub-module; no arithmetic duplicated in the arbiter.
REQ-029 FSM state type SHALL be local to alu_arbiter, not in alu_pkg.

Verification
REQ-030 Single: req0 ADD a=8'd200 b=8'd100, rsp_ready=1 -> rsp_valid 2 cycles after grant, rsp_y=16'd300, rsp_id=0, ops_done=1.
REQ-031 Contention: both valid continuously, req0 MUL 255*255, req1 SUB 3-5, PTR_INIT=0 -> responses alternate id 0,1,0,1; y=16'hFE01 then 16'hFFFE.
REQ-032 Backpressure: rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_y/rsp_id stable, req_ready=00, ops_done unchanged until handshake.
REQ-033 Reset mid-op: rst asserted in EXEC -> next cycle IDLE, rsp_valid=0, ops_done=0, pointer=PTR_INIT.
REQ-034 Saturation: force 65536 handshakes (XOR 8'hAA^8'h55 -> 16'h00FF) -> ops_done holds 16'hFFFF.
REQ-035 Lone requester: only req1 valid with pointer=0 -> req1 granted immediately, pointer becomes 0.
